// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the CAM command sequencer: sizes, command/status codes, FSM states.
package cam_ctrl_pkg;

  localparam int unsigned CAM_NB_MEM    = 14;
  localparam int unsigned CAM_SIZE_ADDR = 4;
  localparam int unsigned CAM_DATA_W    = 8;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_FLUSH  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_MISS = 2'b01,
    ST_DUP  = 2'b10,
    ST_FULL = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEARCH,
    S_EVAL,
    S_WRITE,
    S_RESP
  } state_e;

endpackage

// File: rtl/cam_ctrl_if.sv
// Command and response valid/ready channels of the CAM sequencer.
interface cam_ctrl_if #(
  parameter int unsigned DATA_W    = cam_ctrl_pkg::CAM_DATA_W,
  parameter int unsigned SIZE_ADDR = cam_ctrl_pkg::CAM_SIZE_ADDR
) ();
  import cam_ctrl_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  op_e                  cmd_op;
  logic [DATA_W-1:0]    cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  status_e              rsp_status;
  logic [SIZE_ADDR-1:0] rsp_idx;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_status, rsp_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, rsp_idx
  );
endinterface

// File: rtl/cam_ctrl_free_pick.sv
// Lowest-index free slot finder over the entry valid bitmap.
module cam_ctrl_free_pick #(
  parameter int unsigned NB_MEM    = cam_ctrl_pkg::CAM_NB_MEM,
  parameter int unsigned SIZE_ADDR = cam_ctrl_pkg::CAM_SIZE_ADDR
) (
  input  logic [NB_MEM-1:0]    valid_i,
  output logic [SIZE_ADDR-1:0] f_o,
  output logic                 none_o
);

  // Scan downwards so the lowest invalid index is the last assignment.
  always_comb begin
    f_o    = '0;
    none_o = 1'b1;
    for (int unsigned i = NB_MEM; i > 0; i--) begin
      if (!valid_i[i-1]) begin
        f_o    = SIZE_ADDR'(i - 1);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// Command sequencer for a small CAM: LOOKUP/INSERT/DELETE/FLUSH with a per-entry valid bitmap.
module cam_ctrl import cam_ctrl_pkg::*; #(
  parameter int unsigned NB_MEM    = CAM_NB_MEM,
  parameter int unsigned SIZE_ADDR = CAM_SIZE_ADDR,
  parameter int unsigned DATA_W    = CAM_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  cam_ctrl_if.slave          bus,
  output logic [SIZE_ADDR:0] count,
  output logic               full,
  output logic               empty,
  output logic               cam_enable,
  output logic               cam_write,
  output logic [4:0]         cam_addr,
  output logic [DATA_W-1:0]  cam_data,
  input  logic [4:0]         cam_out,
  input  logic               cam_found
);

  localparam logic [SIZE_ADDR:0] NB_MEM_C = (SIZE_ADDR+1)'(NB_MEM);

  state_e                 state_q, state_d;
  logic [SIZE_ADDR:0]     ptr_q, ptr_d;
  logic [NB_MEM-1:0]      valid_q, valid_d;
  logic [SIZE_ADDR:0]     count_q, count_d;
  op_e                    op_q, op_d;
  logic [DATA_W-1:0]      key_q, key_d;
  status_e                st_q, st_d;
  logic [SIZE_ADDR-1:0]   idx_q, idx_d;
  logic                   cen_q, cen_d, cwr_q, cwr_d;
  logic [4:0]             caddr_q, caddr_d;
  logic [DATA_W-1:0]      cdata_q, cdata_d;
  logic [SIZE_ADDR-1:0]   hit_idx, free_idx;
  logic                   hv, free_none;
  logic                   unused_cam_out;

  cam_ctrl_free_pick #(.NB_MEM(NB_MEM), .SIZE_ADDR(SIZE_ADDR)) u_free_pick (
    .valid_i (valid_q),
    .f_o     (free_idx),
    .none_o  (free_none)
  );

  assign hit_idx        = cam_out[SIZE_ADDR-1:0];
  assign hv             = cam_found && valid_q[hit_idx];
  assign unused_cam_out = ^cam_out;

  // CAM strobes are registered from the next state so they line up with INIT/SEARCH/WRITE
  // and stay low while reset is asserted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    count_d = count_q;
    op_d    = op_q;
    key_d   = key_q;
    st_d    = st_q;
    idx_d   = idx_q;
    cen_d   = 1'b0;
    cwr_d   = 1'b0;
    caddr_d = '0;
    cdata_d = '0;
    unique case (state_q)
      S_INIT: begin
        if (ptr_q == NB_MEM_C) begin
          state_d = S_IDLE;
        end else begin
          cwr_d   = 1'b1;
          caddr_d = 5'(ptr_q);
          cdata_d = DATA_W'(ptr_q);
          ptr_d   = ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          key_d = bus.cmd_data;
          if (bus.cmd_op == OP_FLUSH) begin
            valid_d = '0;
            count_d = '0;
            st_d    = ST_OK;
            idx_d   = '0;
            state_d = S_RESP;
          end else begin
            cen_d   = 1'b1;
            cdata_d = bus.cmd_data;
            state_d = S_SEARCH;
          end
        end
      end
      S_SEARCH: state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_RESP;
        st_d    = ST_OK;
        idx_d   = hit_idx;
        unique case (op_q)
          OP_LOOKUP: if (!hv) begin st_d = ST_MISS; idx_d = '0; end
          OP_DELETE: begin
            if (hv) begin
              valid_d[hit_idx] = 1'b0;
              count_d          = count_q - 1'b1;
            end else begin
              st_d  = ST_MISS;
              idx_d = '0;
            end
          end
          OP_INSERT: begin
            if (hv) begin
              st_d = ST_DUP;
            end else if (cam_found) begin
              // Key already sits in an invalidated word: revive it, no CAM write.
              valid_d[hit_idx] = 1'b1;
              count_d          = count_q + 1'b1;
            end else if (free_none) begin
              st_d  = ST_FULL;
              idx_d = '0;
            end else begin
              state_d = S_WRITE;
              cwr_d   = 1'b1;
              caddr_d = 5'(free_idx);
              cdata_d = key_q;
            end
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        valid_d[caddr_q[SIZE_ADDR-1:0]] = 1'b1;
        count_d = count_q + 1'b1;
        st_d    = ST_OK;
        idx_d   = caddr_q[SIZE_ADDR-1:0];
        state_d = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      valid_q <= '0;
      count_q <= '0;
      op_q    <= OP_LOOKUP;
      key_q   <= '0;
      st_q    <= ST_OK;
      idx_q   <= '0;
      cen_q   <= 1'b0;
      cwr_q   <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      count_q <= count_d;
      op_q    <= op_d;
      key_q   <= key_d;
      st_q    <= st_d;
      idx_q   <= idx_d;
      cen_q   <= cen_d;
      cwr_q   <= cwr_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_status = st_q;
  assign bus.rsp_idx    = idx_q;
  assign count          = count_q;
  assign full           = (count_q == NB_MEM_C);
  assign empty          = (count_q == '0);
  assign cam_enable     = cen_q;
  assign cam_write      = cwr_q;
  assign cam_addr       = caddr_q;
  assign cam_data       = cdata_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM, reference model feeding a response scoreboard.
module tb_cam_ctrl;
  import cam_ctrl_pkg::*;

  typedef struct {
    status_e st;
    int      idx;
    int      lat;
    int      nwr;
    int      cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] count;
  logic       full, empty, cam_enable, cam_write, cam_found;
  logic [4:0] cam_addr, cam_out;
  logic [7:0] cam_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int wr_addr, wr_data;

  logic [7:0]  cmem [14];
  logic [7:0]  mcam [14];
  logic [13:0] mvalid;
  exp_t        sb [$];

  always #5 clk = ~clk;

  cam_ctrl_if bus ();

  cam_ctrl #(.NB_MEM(14), .SIZE_ADDR(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .cam_enable (cam_enable),
    .cam_write  (cam_write),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found)
  );

  // Behavioural CAM: single write port, registered search result.
  always @(posedge clk) begin
    if (cam_write && cam_addr < 5'd14) cmem[cam_addr[3:0]] <= cam_data;
    if (cam_enable) begin
      cam_found <= 1'b0;
      cam_out   <= 5'd0;
      for (int i = 0; i < 14; i++)
        if (cmem[i] == cam_data) begin
          cam_found <= 1'b1;
          cam_out   <= 5'(i);
        end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cam_write) begin
        wr_cnt++;
        wr_addr = int'(cam_addr);
        wr_data = int'(cam_data);
      end
      if (cam_write && cam_enable) both_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 14; k++) mcam[k] = 8'(k);
    mvalid = '0;
  endtask

  task automatic model(input op_e op, input logic [7:0] key, output exp_t e);
    int h = -1;
    int f = -1;
    e = '{st: ST_OK, idx: 0, lat: 3, nwr: 0, cnt: 0};
    for (int i = 0; i < 14; i++) if (mcam[i] == key) h = i;
    for (int i = 13; i >= 0; i--) if (!mvalid[i]) f = i;
    case (op)
      OP_LOOKUP: if (h >= 0 && mvalid[h]) e.idx = h; else e.st = ST_MISS;
      OP_DELETE: if (h >= 0 && mvalid[h]) begin e.idx = h; mvalid[h] = 1'b0; end
                 else e.st = ST_MISS;
      OP_INSERT: begin
        if (h >= 0 && mvalid[h]) begin e.st = ST_DUP; e.idx = h; end
        else if (h >= 0) begin mvalid[h] = 1'b1; e.idx = h; end
        else if (f < 0) e.st = ST_FULL;
        else begin
          mcam[f] = key; mvalid[f] = 1'b1; e.idx = f; e.lat = 4; e.nwr = 1;
        end
      end
      default: begin mvalid = '0; e.lat = 1; end
    endcase
    e.cnt = $countones(mvalid);
  endtask

  task automatic run_cmd(input op_e op, input logic [7:0] key, input int hold);
    exp_t e;
    int   n, lat, wr0;
    model(op, key, e);
    sb.push_back(e);
    wr0 = wr_cnt;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 32'(n < 50), 1);
    bus.rsp_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = key;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 20);
    e = sb.pop_front();
    chk($sformatf("lat op%0d key%0h", op, key), lat, e.lat);
    chk($sformatf("status key%0h", key), bus.rsp_status, e.st);
    chk($sformatf("idx key%0h", key), bus.rsp_idx, e.idx);
    chk("count", count, e.cnt);
    chk("full", full, 32'(e.cnt == 14));
    chk("empty", empty, 32'(e.cnt == 0));
    chk("cam_writes", wr_cnt - wr0, e.nwr);
    if (e.nwr == 1) begin
      chk("wr_addr", wr_addr, e.idx);
      chk("wr_data", wr_data, key);
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_status", bus.rsp_status, e.st);
      chk("hold_idx", bus.rsp_idx, e.idx);
      chk("hold_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_init();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("init_wr%0d", k), cam_write, 1);
      chk($sformatf("init_addr%0d", k), cam_addr, k);
      chk($sformatf("init_data%0d", k), cam_data, k);
      chk($sformatf("init_ready%0d", k), bus.cmd_ready, 0);
    end
    @(negedge clk);
    chk("init_done_ready", bus.cmd_ready, 1);
    chk("init_done_wr", cam_write, 0);
    chk("init_empty", empty, 1);
    chk("init_count", count, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    #1;
    chk("rst_wr", cam_write, 0);
    chk("rst_en", cam_enable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_status", bus.rsp_status, 0);
    chk("rst_rsp_idx", bus.rsp_idx, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    check_init();
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOOKUP;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    #12;
    do_reset();

    run_cmd(OP_INSERT, 8'hA5, 0);
    run_cmd(OP_LOOKUP, 8'hA5, 0);
    run_cmd(OP_INSERT, 8'hA5, 0);

    do_reset();
    run_cmd(OP_INSERT, 8'h05, 0);

    run_cmd(OP_FLUSH, 8'h00, 0);
    for (int k = 0; k < 14; k++) run_cmd(OP_INSERT, 8'(8'h80 + k), 0);
    run_cmd(OP_INSERT, 8'h90, 0);
    run_cmd(OP_DELETE, 8'h83, 0);
    run_cmd(OP_INSERT, 8'h90, 0);

    run_cmd(OP_LOOKUP, 8'h83, 0);
    run_cmd(OP_FLUSH, 8'h00, 0);
    run_cmd(OP_LOOKUP, 8'h80, 0);

    run_cmd(OP_INSERT, 8'h11, 5);

    // Reset asserted while the controller sits in WRITE.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_INSERT;
    bus.cmd_data  = 8'h42;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    while (!cam_write && n < 10) begin @(negedge clk); n++; end
    chk("wr_seen_before_rst", cam_write, 1);
    chk("count_before_rst", count, 1);
    #2;
    do_reset();

    for (int t = 0; t < 30; t++) begin
      logic [7:0] key;
      op_e        op;
      key = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'(8'h80 + $urandom_range(0, 7));
      op  = ($urandom_range(0, 15) == 0) ? OP_FLUSH : op_e'($urandom_range(0, 2));
      run_cmd(op, key, 0);
    end

    chk("write_enable_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
